// File: rtl/tumbler_draw_sequencer.sv
// Feeds the tumbler square-drawer: snapshots the lock state on start, then paces one
// press/settle draw request per tumbler purely by cycle count (the drawer has no handshake).
module tumbler_draw_sequencer #(
  parameter int         NUM_TUMBLERS  = 4,
  parameter int         POS_BITS      = 3,
  parameter int         CUR_BITS      = 2,
  parameter logic [7:0] X_BASE        = 8'd20,
  parameter logic [7:0] X_STEP        = 8'd30,
  parameter logic [7:0] Y_BASE        = 8'd40,
  parameter logic [7:0] Y_STEP        = 8'd6,
  parameter int         PRESS_CYCLES  = 4,
  parameter int         SETTLE_CYCLES = 1100
) (
  input  logic                             clock,
  input  logic                             resetn,
  input  logic                             start,
  input  logic [NUM_TUMBLERS*POS_BITS-1:0] positions,
  input  logic [NUM_TUMBLERS*POS_BITS-1:0] targets,
  input  logic [CUR_BITS-1:0]              cursor,
  output logic [7:0]                       x_out,
  output logic [7:0]                       y_out,
  output logic [2:0]                       colour_out,
  output logic                             draw_full,
  output logic                             draw,
  output logic                             busy,
  output logic                             done,
  output logic [1:0]                       state_dbg
);

  // Handshake: none. start is a 1-cycle request accepted only in IDLE; draw is an
  // active-low strobe held for PRESS_CYCLES, then high for SETTLE_CYCLES.
  localparam int IDX_W   = (NUM_TUMBLERS > 1) ? $clog2(NUM_TUMBLERS) : 1;
  localparam int CNT_MAX = (PRESS_CYCLES > SETTLE_CYCLES) ? PRESS_CYCLES : SETTLE_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_TUMBLERS - 1);
  localparam logic [CNT_W-1:0] PRESS_LAST  = CNT_W'(PRESS_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_PRESS  = 2'd1,
    S_SETTLE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t                           state, state_nx;
  logic [CNT_W-1:0]                 cnt, cnt_nx;
  logic [IDX_W-1:0]                 idx, idx_nx;
  logic                             load;
  logic [NUM_TUMBLERS*POS_BITS-1:0] pos_snap, tgt_snap;
  logic [CUR_BITS-1:0]              cur_snap;

  logic [NUM_TUMBLERS*POS_BITS-1:0] src_pos, src_tgt;
  logic [CUR_BITS-1:0]              src_cur;
  logic [POS_BITS-1:0]              sel_pos, sel_tgt;
  logic [7:0]                       x_nx, y_nx;
  logic [2:0]                       colour_nx;
  logic                             full_nx, draw_nx, busy_nx, done_nx;

  assign state_dbg = state;

  // State register plus registered outputs, so draw/busy/done never glitch.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state      <= S_IDLE;
      cnt        <= '0;
      idx        <= '0;
      pos_snap   <= '0;
      tgt_snap   <= '0;
      cur_snap   <= '0;
      x_out      <= '0;
      y_out      <= '0;
      colour_out <= '0;
      draw_full  <= 1'b0;
      draw       <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      idx   <= idx_nx;
      draw  <= draw_nx;
      busy  <= busy_nx;
      done  <= done_nx;
      if (state == S_IDLE && start) begin
        pos_snap <= positions;
        tgt_snap <= targets;
        cur_snap <= cursor;
      end
      if (load) begin
        x_out      <= x_nx;
        y_out      <= y_nx;
        colour_out <= colour_nx;
        draw_full  <= full_nx;
      end
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    idx_nx   = idx;
    load     = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nx = S_PRESS;
          cnt_nx   = '0;
          idx_nx   = '0;
          load     = 1'b1;
        end
      end
      S_PRESS: begin
        if (cnt == PRESS_LAST) begin
          state_nx = S_SETTLE;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      S_SETTLE: begin
        if (cnt == SETTLE_LAST) begin
          cnt_nx = '0;
          if (idx == LAST_IDX) begin
            state_nx = S_DONE;
          end else begin
            state_nx = S_PRESS;
            idx_nx   = idx + 1'b1;
            load     = 1'b1;
          end
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // On the first request the snapshot is being captured on the same edge, so read live inputs.
  always_comb begin
    src_pos   = (state == S_IDLE) ? positions : pos_snap;
    src_tgt   = (state == S_IDLE) ? targets   : tgt_snap;
    src_cur   = (state == S_IDLE) ? cursor    : cur_snap;
    sel_pos   = src_pos[idx_nx*POS_BITS +: POS_BITS];
    sel_tgt   = src_tgt[idx_nx*POS_BITS +: POS_BITS];
    x_nx      = X_BASE + 8'(idx_nx) * X_STEP;
    y_nx      = Y_BASE + 8'(sel_pos) * Y_STEP;
    colour_nx = (sel_pos == sel_tgt) ? 3'b010 : 3'b100;
    full_nx   = (32'(src_cur) == 32'(idx_nx));
    draw_nx   = (state_nx != S_PRESS);
    busy_nx   = (state_nx == S_PRESS) || (state_nx == S_SETTLE);
    done_nx   = (state_nx == S_DONE);
  end

endmodule

// File: tb/tb_tumbler_draw_sequencer.sv
// Directed bench for tumbler_draw_sequencer: default instance plus a small wrap/cursor instance.
`timescale 1ns/1ps
module tb_tumbler_draw_sequencer;

  logic        clock = 1'b0;
  logic        resetn;
  logic        start, start2;
  logic [11:0] positions, targets;
  logic [8:0]  positions2, targets2;
  logic [1:0]  cursor, cursor2;

  logic [7:0]  x_out, y_out, x2, y2;
  logic [2:0]  colour_out, colour2;
  logic        draw_full, draw, busy, done, full2, draw2, busy2, done2;
  logic [1:0]  state_dbg, state2;

  logic [19:0] exp_q[$];
  logic [19:0] got_q[$];
  logic [19:0] got2_q[$];
  int          fall_cnt = 0;
  logic        draw_prev = 1'b1, draw2_prev = 1'b1;
  int          n_pass = 0, n_total = 0;
  int          cyc, bad, base, n;

  // Clock / reset
  always #10 clock = ~clock;

  initial begin
    #3_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  tumbler_draw_sequencer u_dut (
    .clock(clock), .resetn(resetn), .start(start), .positions(positions), .targets(targets),
    .cursor(cursor), .x_out(x_out), .y_out(y_out), .colour_out(colour_out),
    .draw_full(draw_full), .draw(draw), .busy(busy), .done(done), .state_dbg(state_dbg)
  );

  tumbler_draw_sequencer #(
    .NUM_TUMBLERS(3), .Y_BASE(8'd250), .PRESS_CYCLES(2), .SETTLE_CYCLES(3)
  ) u_wrap (
    .clock(clock), .resetn(resetn), .start(start2), .positions(positions2), .targets(targets2),
    .cursor(cursor2), .x_out(x2), .y_out(y2), .colour_out(colour2),
    .draw_full(full2), .draw(draw2), .busy(busy2), .done(done2), .state_dbg(state2)
  );

  // Capture every request at the falling edge of draw
  always @(negedge clock) begin
    if (draw_prev && !draw) begin
      got_q.push_back({x_out, y_out, colour_out, draw_full});
      fall_cnt++;
    end
    if (draw2_prev && !draw2) got2_q.push_back({x2, y2, colour2, full2});
    draw_prev  = draw;
    draw2_prev = draw2;
  end

  function automatic logic [19:0] req(input int x, input int y, input int c, input int f);
    return {8'(x), 8'(y), 3'(c), 1'(f)};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Driver tasks
  task automatic start_pulse();
    @(negedge clock) start = 1'b1;
    @(negedge clock) start = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int c, output int b);
    c = 0;
    b = 0;
    while (done !== 1'b1 && c < limit) begin
      if (busy !== 1'b1) b++;
      @(negedge clock);
      c++;
    end
  endtask

  task automatic wait_falls(input int target, input int limit);
    int k;
    k = 0;
    while (fall_cnt < target && k < limit) begin
      @(negedge clock);
      k++;
    end
  endtask

  // Scoreboard: match captured requests against the expected queue
  task automatic drain(input string tag, input bit second);
    logic [19:0] e, o;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (second) o = (got2_q.size() > 0) ? got2_q.pop_front() : 20'hfffff;
      else        o = (got_q.size()  > 0) ? got_q.pop_front()  : 20'hfffff;
      check(tag, 32'(o), 32'(e));
    end
    check({tag, "_extra"}, second ? got2_q.size() : got_q.size(), 0);
  endtask

  initial begin
    resetn = 1'b0; start = 1'b0; start2 = 1'b0;
    positions = '0; targets = '0; cursor = '0;
    positions2 = '0; targets2 = '0; cursor2 = '0;
    repeat (3) @(negedge clock);
    check("rst_draw", draw, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_xy", {x_out, y_out}, 0);
    check("rst_colour_full", {colour_out, draw_full}, 0);
    check("rst_state", state_dbg, 0);
    resetn = 1'b1;
    @(negedge clock);

    // Basic frame, exact latency and busy envelope
    positions = {3'd3, 3'd0, 3'd5, 3'd2};
    targets   = {3'd3, 3'd1, 3'd5, 3'd0};
    cursor    = 2'd1;
    exp_q.push_back(req(20, 52, 3'b100, 0));
    exp_q.push_back(req(50, 70, 3'b010, 1));
    exp_q.push_back(req(80, 40, 3'b100, 0));
    exp_q.push_back(req(110, 58, 3'b010, 0));
    start_pulse();
    check("t1_first_draw", draw, 0);
    check("t1_first_busy", busy, 1);
    check("t1_first_x", x_out, 20);
    wait_done(6000, cyc, bad);
    check("t2_latency", cyc, 4416);
    check("t2_busy_gaps", bad, 0);
    check("t2_busy_on_done", busy, 0);
    check("t2_draw_on_done", draw, 1);
    drain("t1_req", 1'b0);
    @(negedge clock);
    check("t2_done_pulse", done, 0);
    check("t2_hold_x", x_out, 110);

    // Restart while busy is ignored; snapshot survives input changes
    positions = {3'd7, 3'd6, 3'd1, 3'd4};
    targets   = {3'd7, 3'd0, 3'd1, 3'd4};
    cursor    = 2'd3;
    exp_q.push_back(req(20, 64, 3'b010, 0));
    exp_q.push_back(req(50, 46, 3'b010, 0));
    exp_q.push_back(req(80, 76, 3'b100, 0));
    exp_q.push_back(req(110, 82, 3'b010, 1));
    base = fall_cnt;
    start_pulse();
    wait_falls(base + 2, 3000);
    positions = '0; targets = '1; cursor = 2'd0;
    start = 1'b1;
    @(negedge clock) start = 1'b0;
    wait_done(6000, cyc, bad);
    check("t3_done_seen", done, 1);
    start = 1'b1;
    @(negedge clock) start = 1'b0;
    check("t3_start_in_done_busy", busy, 0);
    check("t3_start_in_done_state", state_dbg, 0);
    repeat (20) @(negedge clock);
    check("t3_fall_count", fall_cnt, base + 4);
    check("t3_still_idle", busy, 0);
    drain("t3_req", 1'b0);

    // Asynchronous reset during the third press
    positions = {3'd3, 3'd0, 3'd5, 3'd2};
    cursor    = 2'd1;
    base = fall_cnt;
    start_pulse();
    wait_falls(base + 3, 4000);
    check("t4_in_press", draw, 0);
    check("t4_press_x", x_out, 80);
    #1 resetn = 1'b0;
    #1;
    check("t4_draw_async", draw, 1);
    check("t4_busy_async", busy, 0);
    check("t4_x_cleared", x_out, 0);
    @(negedge clock) resetn = 1'b1;
    repeat (50) @(negedge clock);
    check("t4_no_more_falls", fall_cnt, base + 3);
    check("t4_idle", {busy, draw}, 2'b01);
    got_q.delete();

    // y wrap and out-of-range cursor on the 3-tumbler instance
    positions2 = {3'd5, 3'd0, 3'd3};
    targets2   = {3'd5, 3'd0, 3'd1};
    cursor2    = 2'd3;
    exp_q.push_back(req(20, 12, 3'b100, 0));
    exp_q.push_back(req(50, 250, 3'b010, 0));
    exp_q.push_back(req(80, 24, 3'b010, 0));
    @(negedge clock) start2 = 1'b1;
    @(negedge clock) start2 = 1'b0;
    n = 0;
    while (done2 !== 1'b1 && n < 100) begin
      @(negedge clock);
      n++;
    end
    check("t5_latency", n, 15);
    drain("t5_req", 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
